// File: rtl/pcm_playback_buffer.sv
// PCM playback FIFO with a sample-rate divider and an IDLE/PRIME/PLAY/STARVE sequencer.
// Optional build macro PCM_UNDERRUN_COUNT_EN adds a saturating 16-bit underrun_count output.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | playback disabled, sample_out parked at midscale 64
// PRIME  | enabled, waiting for fill to reach PRIME_LEVEL
// PLAY   | divider running, one pop per SAMPLE_DIV cycles
// STARVE | FIFO ran dry at a boundary, waiting to re-prime

module pcm_playback_buffer #(
    parameter int DEPTH       = 16,
    parameter int SAMPLE_DIV  = 2048,
    parameter int PRIME_LEVEL = DEPTH / 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [6:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [6:0]               sample_out,
    output logic                     sample_tick,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     underrun
`ifdef PCM_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]              underrun_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [FW-1:0] C_DEPTH    = FW'(DEPTH);
    localparam logic [FW-1:0] C_PRIME    = FW'(PRIME_LEVEL);
    localparam logic [CW-1:0] C_DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [6:0]    C_MIDSCALE = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_STARVE = 2'd3
    } state_t;

    state_t          r_state;
    logic [6:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [FW-1:0]   r_fill;
    logic [CW-1:0]   r_div;
    logic [6:0]      r_sample_out;
    logic            r_sample_tick;
    logic            r_underrun;
`ifdef PCM_UNDERRUN_COUNT_EN
    logic [15:0]     r_underrun_count;
`endif

    logic w_push;
    logic w_boundary;
    logic w_pop;
    logic w_primed;

    assign s_ready    = (r_fill < C_DEPTH) && rst_n;
    assign w_push     = s_valid && s_ready;
    // enable=0 overrides everything, so a boundary never fires in the disabling cycle
    assign w_boundary = enable && (r_state == ST_PLAY) && (r_div == C_DIV_LAST);
    assign w_pop      = w_boundary && (r_fill != '0);
    assign w_primed   = (r_fill >= C_PRIME);

    assign sample_out  = r_sample_out;
    assign sample_tick = r_sample_tick;
    assign fill        = r_fill;
    assign underrun    = r_underrun;
`ifdef PCM_UNDERRUN_COUNT_EN
    assign underrun_count = r_underrun_count;
`endif

    // Storage is cleared on reset so nothing buffered survives it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= s_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_div            <= '0;
            r_sample_out     <= C_MIDSCALE;
            r_sample_tick    <= 1'b0;
            r_underrun       <= 1'b0;
`ifdef PCM_UNDERRUN_COUNT_EN
            r_underrun_count <= '0;
`endif
        end else begin
            r_sample_tick <= 1'b0;
            if (!enable) begin
                r_state      <= ST_IDLE;
                r_div        <= '0;
                r_sample_out <= C_MIDSCALE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state          <= ST_PRIME;
                        r_div            <= '0;
                        r_underrun       <= 1'b0;
`ifdef PCM_UNDERRUN_COUNT_EN
                        r_underrun_count <= '0;
`endif
                    end
                    ST_PRIME, ST_STARVE: begin
                        r_div <= '0;
                        if (w_primed) begin
                            r_state <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (w_boundary) begin
                            r_div <= '0;
                            if (w_pop) begin
                                r_sample_out  <= r_mem[r_rd_ptr];
                                r_sample_tick <= 1'b1;
                            end else begin
                                r_state    <= ST_STARVE;
                                r_underrun <= 1'b1;
`ifdef PCM_UNDERRUN_COUNT_EN
                                if (r_underrun_count != 16'hFFFF) begin
                                    r_underrun_count <= r_underrun_count + 1'b1;
                                end
`endif
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_div   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pcm_playback_buffer.sv
// Self-checking bench for pcm_playback_buffer: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.

module tb_pcm_playback_buffer;

    localparam int DEPTH       = 4;
    localparam int SAMPLE_DIV  = 8;
    localparam int PRIME_LEVEL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [6:0] sample_out;
    logic       sample_tick;
    logic [2:0] fill;
    logic       underrun;
`ifdef PCM_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;
`endif

    int errors = 0;
    int checks = 0;

    pcm_playback_buffer #(
        .DEPTH      (DEPTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .PRIME_LEVEL(PRIME_LEVEL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sample_out (sample_out),
        .sample_tick(sample_tick),
        .fill       (fill),
        .underrun   (underrun)
`ifdef PCM_UNDERRUN_COUNT_EN
        ,
        .underrun_count(underrun_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: PRIME and STARVE behave identically, so one "armed but not playing" flag covers both.
    int  q[$];
    bit  m_armed;
    bit  m_playing;
    int  m_age;
    int  m_out;
    bit  m_tick;
    bit  m_und;
    int  m_ucnt;

    task automatic model_reset();
        q.delete();
        m_armed   = 0;
        m_playing = 0;
        m_age     = 0;
        m_out     = 64;
        m_tick    = 0;
        m_und     = 0;
        m_ucnt    = 0;
    endtask

    task automatic model_step();
        int pre;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pre    = q.size();
        m_tick = 0;
        if (!enable) begin
            m_armed   = 0;
            m_playing = 0;
            m_out     = 64;
        end else if (!m_armed) begin
            m_armed = 1;
            m_und   = 0;
            m_ucnt  = 0;
        end else if (!m_playing) begin
            if (pre >= PRIME_LEVEL) begin
                m_playing = 1;
                m_age     = 0;
            end
        end else begin
            if (m_age % SAMPLE_DIV == SAMPLE_DIV - 1) begin
                if (pre > 0) begin
                    m_out  = q.pop_front();
                    m_tick = 1;
                end else begin
                    m_playing = 0;
                    m_und     = 1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            m_age++;
        end
        if (s_valid && pre < DEPTH) q.push_back(int'(s_data));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("sample_out", 32'(sample_out), 32'(m_out));
        chk("sample_tick", 32'(sample_tick), 32'(m_tick));
        chk("fill", 32'(fill), 32'(q.size()));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("s_ready", 32'(s_ready), 32'(rst_n && (q.size() < DEPTH)));
`ifdef PCM_UNDERRUN_COUNT_EN
        chk("underrun_count", 32'(underrun_count), 32'(m_ucnt));
`endif
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();

        // Reset and idle
        repeat (2) cyc();
        chk("rst_out", 32'(sample_out), 32'd64);
        chk("rst_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("idle_out", 32'(sample_out), 32'd64);
        chk("idle_fill", 32'(fill), 32'd0);
        chk("idle_ready", 32'(s_ready), 32'd1);

        // Prime and play 10, 20, 30
        s_valid = 1'b1;
        s_data = 7'd10; cyc();
        s_data = 7'd20; cyc();
        s_data = 7'd30; cyc();
        s_valid = 1'b0;
        enable  = 1'b1;
        cyc();
        cyc();
        repeat (7) cyc();
        cyc();
        chk("play_tick1", 32'(sample_tick), 32'd1);
        chk("play_val1", 32'(sample_out), 32'd10);
        repeat (7) cyc();
        cyc();
        chk("play_val2", 32'(sample_out), 32'd20);
        repeat (7) cyc();
        cyc();
        chk("play_val3", 32'(sample_out), 32'd30);

        // Starve at the next boundary
        repeat (8) cyc();
        chk("starve_und", 32'(underrun), 32'd1);
        chk("starve_hold", 32'(sample_out), 32'd30);
        chk("starve_tick", 32'(sample_tick), 32'd0);

        // Resume with two writes; divider restarts on re-entry
        s_valid = 1'b1;
        s_data = 7'd40; cyc();
        s_data = 7'd50; cyc();
        s_valid = 1'b0;
        cyc();
        n = 0;
        while (!sample_tick && n < 20) begin
            cyc();
            n++;
        end
        chk("resume_latency", 32'(n), 32'd8);
        chk("resume_val", 32'(sample_out), 32'd40);

        // Disable mid-play, then reset
        enable = 1'b0;
        cyc();
        chk("dis_out", 32'(sample_out), 32'd64);
        chk("dis_fill", 32'(fill), 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("rst2_fill", 32'(fill), 32'd0);
        chk("rst2_und", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Full: five back-to-back writes, only four fit
        for (int k = 1; k <= 5; k++) begin
            s_valid = 1'b1;
            s_data  = 7'(k);
            cyc();
        end
        chk("full_fill", 32'(fill), 32'd4);
        chk("full_ready", 32'(s_ready), 32'd0);
        enable = 1'b1;
        n = 0;
        while (!sample_tick && n < 30) begin
            cyc();
            n++;
        end
        chk("full_tick_seen", 32'(sample_tick), 32'd1);
        chk("full_first", 32'(sample_out), 32'd1);
        cyc();
        chk("full_refill", 32'(fill), 32'd4);
        s_valid = 1'b0;

        // Random traffic in segments of differing write density
        for (int seg = 0; seg < 4; seg++) begin
            int wden;
            wden = (seg == 0) ? 4 : (seg == 1) ? 12 : (seg == 2) ? 2 : 8;
            for (int i = 0; i < 400; i++) begin
                rst_n   = ($urandom_range(0, 299) != 0);
                enable  = ($urandom_range(0, 39) != 0);
                s_valid = ($urandom_range(0, wden - 1) == 0);
                s_data  = 7'($urandom_range(0, 127));
                cyc();
            end
        end
        rst_n   = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
